// File: rtl/mips_mem_pkg.sv
// Shared types and constants for the MEM-stage data-memory access unit.
package mips_mem_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      WORD1 = 1'b1
   } mem_state_e;

   localparam logic [3:0]  BE_WORD     = 4'hF;
   localparam logic [3:0]  BE_BYTE0    = 4'b0001;
   localparam int unsigned WORD_STRIDE = 4;

endpackage : mips_mem_pkg

// File: rtl/mem_byte_lane.sv
// Byte-enable and write-data lane steering for word and byte stores.
module mem_byte_lane
   import mips_mem_pkg::*;
(
   input  logic [1:0]  byte_sel,
   input  logic        store_byte,
   input  logic [31:0] data,
   output logic [3:0]  be,
   output logic [31:0] wdata
);

   // A byte store replicates the byte on every lane so the memory picks it up by enable alone.
   always_comb begin
      if (store_byte) begin
         be    = BE_BYTE0 << byte_sel;
         wdata = {4{data[7:0]}};
      end else begin
         be    = BE_WORD;
         wdata = data;
      end
   end

endmodule : mem_byte_lane

// File: rtl/mem_access_unit.sv
// MEM-stage data-memory access controller: one or two word accesses over a req/ready port,
// with pipeline stall generation, alignment checking and a saturating stall-cycle counter.
module mem_access_unit
   import mips_mem_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int CNT_W  = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [ADDR_W-1:0] resultAlu_M,
   input  logic [31:0]       readdata2_M,
   input  logic [31:0]       readdata_double2_M,
   input  logic              memread_M,
   input  logic              memwrite_M,
   input  logic              storeByte_M,
   input  logic              double_M,
   output logic              dmem_req,
   output logic              dmem_we,
   output logic [ADDR_W-1:0] dmem_addr,
   output logic [3:0]        dmem_be,
   output logic [31:0]       dmem_wdata,
   input  logic              dmem_ready,
   input  logic [31:0]       dmem_rdata,
   output logic [31:0]       readdata_M,
   output logic [31:0]       readdata_double_M,
   output logic              mem_stall,
   output logic              misalign_M,
   output logic [CNT_W-1:0]  stall_cnt
);

   mem_state_e        state_q, state_d;
   logic [31:0]       lo_q;
   logic              acc_req, acc, is_byte, is_double, in_word1, final_word;
   logic [ADDR_W-1:0] base_addr;
   logic [3:0]        lane_be;
   logic [31:0]       lane_wdata;

   assign acc_req    = memread_M | memwrite_M;
   assign misalign_M = acc_req & ((!storeByte_M & (resultAlu_M[1:0] != 2'b00))
                                 | (double_M & resultAlu_M[2]));
   assign acc        = acc_req & !misalign_M;
   // A byte store always wins over the double flag: it is a single-word access.
   assign is_byte    = storeByte_M & memwrite_M;
   assign is_double  = double_M & !is_byte;
   assign in_word1   = (state_q == WORD1);
   assign final_word = in_word1 | !is_double;
   assign base_addr  = {resultAlu_M[ADDR_W-1:2], 2'b00};

   mem_byte_lane u_byte_lane (
      .byte_sel   (resultAlu_M[1:0]),
      .store_byte (is_byte),
      .data       (readdata2_M),
      .be         (lane_be),
      .wdata      (lane_wdata)
   );

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // NOTE: every combinational output gets a default first, so no path can infer a latch.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (acc && dmem_ready && is_double) state_d = WORD1;
         WORD1:   if (dmem_ready)                     state_d = IDLE;
         default:                                     state_d = IDLE;
      endcase
   end

   // Request and stall are gated by rst_n so an asserted reset drops them without waiting for a clock.
   always_comb begin
      dmem_req          = acc & rst_n;
      dmem_we           = memwrite_M;
      dmem_addr         = base_addr;
      dmem_be           = lane_be;
      dmem_wdata        = lane_wdata;
      readdata_M        = dmem_rdata;
      readdata_double_M = '0;
      mem_stall         = rst_n & acc & !(final_word & dmem_ready);
      if (in_word1) begin
         dmem_addr         = base_addr + ADDR_W'(WORD_STRIDE);
         dmem_wdata        = readdata_double2_M;
         readdata_M        = lo_q;
         readdata_double_M = dmem_rdata;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         lo_q <= '0;
      else if (!in_word1 && acc && dmem_ready && is_double && !memwrite_M)
         lo_q <= dmem_rdata;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         stall_cnt <= '0;
      else if (mem_stall && (stall_cnt != {CNT_W{1'b1}}))
         stall_cnt <= stall_cnt + 1'b1;
   end

endmodule : mem_access_unit

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: directed accesses push expected memory transactions,
// a negedge monitor pops and compares each accepted request.
module tb_mem_access_unit;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] resultAlu_M, readdata2_M, readdata_double2_M;
   logic        memread_M, memwrite_M, storeByte_M, double_M;
   logic        dmem_ready;
   logic [31:0] dmem_rdata;

   logic        dmem_req, dmem_we, mem_stall, misalign_M;
   logic [31:0] dmem_addr, dmem_wdata, readdata_M, readdata_double_M, stall_cnt;
   logic [3:0]  dmem_be;

   logic        s_req, s_we, s_stall, s_mis;
   logic [31:0] s_addr, s_wdata, s_rd, s_rdd;
   logic [3:0]  s_be;
   logic [2:0]  s_cnt;

   always #5 clk = ~clk;

   mem_access_unit #(.ADDR_W(32), .CNT_W(32)) dut (
      .clk(clk), .rst_n(rst_n), .resultAlu_M(resultAlu_M), .readdata2_M(readdata2_M),
      .readdata_double2_M(readdata_double2_M), .memread_M(memread_M), .memwrite_M(memwrite_M),
      .storeByte_M(storeByte_M), .double_M(double_M), .dmem_req(dmem_req), .dmem_we(dmem_we),
      .dmem_addr(dmem_addr), .dmem_be(dmem_be), .dmem_wdata(dmem_wdata), .dmem_ready(dmem_ready),
      .dmem_rdata(dmem_rdata), .readdata_M(readdata_M), .readdata_double_M(readdata_double_M),
      .mem_stall(mem_stall), .misalign_M(misalign_M), .stall_cnt(stall_cnt)
   );

   mem_access_unit #(.ADDR_W(32), .CNT_W(3)) dut_sat (
      .clk(clk), .rst_n(rst_n), .resultAlu_M(resultAlu_M), .readdata2_M(readdata2_M),
      .readdata_double2_M(readdata_double2_M), .memread_M(memread_M), .memwrite_M(memwrite_M),
      .storeByte_M(storeByte_M), .double_M(double_M), .dmem_req(s_req), .dmem_we(s_we),
      .dmem_addr(s_addr), .dmem_be(s_be), .dmem_wdata(s_wdata), .dmem_ready(dmem_ready),
      .dmem_rdata(dmem_rdata), .readdata_M(s_rd), .readdata_double_M(s_rdd),
      .mem_stall(s_stall), .misalign_M(s_mis), .stall_cnt(s_cnt)
   );

   typedef struct {
      string       name;
      logic [31:0] addr;
      logic        we;
      logic [3:0]  be;
      logic [31:0] wdata;
      logic        stall;
      logic [31:0] rd;
      logic [31:0] rdd;
   } exp_t;

   exp_t exp_q[$];
   int   n_cmp  = 0;
   int   n_fail = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      n_cmp++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
      end
   endtask

   // Monitor: every accepted request must match the next queued expectation.
   always @(negedge clk) begin
      if (rst_n && dmem_req && dmem_ready) begin
         if (exp_q.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL unexpected_req: addr 0x%0h with empty scoreboard", dmem_addr);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            check({e.name, ".addr"},  64'(dmem_addr), 64'(e.addr));
            check({e.name, ".we"},    64'(dmem_we),   64'(e.we));
            check({e.name, ".be"},    64'(dmem_be),   64'(e.be));
            check({e.name, ".stall"}, 64'(mem_stall), 64'(e.stall));
            if (e.we) check({e.name, ".wdata"}, 64'(dmem_wdata), 64'(e.wdata));
            else if (!e.stall) begin
               check({e.name, ".rd"},  64'(readdata_M),        64'(e.rd));
               check({e.name, ".rdd"}, 64'(readdata_double_M), 64'(e.rdd));
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input string name, input logic [31:0] addr, input logic we, input logic [3:0] be,
                       input logic [31:0] wdata, input logic stall, input logic [31:0] rd, input logic [31:0] rdd);
      exp_t e;
      e = '{name, addr, we, be, wdata, stall, rd, rdd};
      exp_q.push_back(e);
   endtask

   // Present one memory word: `delay` not-ready cycles, then one ready cycle with rdata.
   task automatic serve_word(input int delay, input logic [31:0] rdata);
      for (int d = 0; d <= delay; d++) begin
         dmem_ready = (d == delay);
         dmem_rdata = (d == delay) ? rdata : 32'h0;
         tick();
      end
      dmem_ready = 1'b0;
      dmem_rdata = 32'h0;
   endtask

   task automatic set_op(input logic [31:0] addr, input logic rd, input logic wr, input logic sb,
                         input logic dbl, input logic [31:0] wd0, input logic [31:0] wd1);
      resultAlu_M = addr; memread_M = rd; memwrite_M = wr; storeByte_M = sb; double_M = dbl;
      readdata2_M = wd0; readdata_double2_M = wd1;
   endtask

   task automatic idle_op();
      set_op(32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
   endtask

   initial begin
      idle_op();
      dmem_ready = 1'b0;
      dmem_rdata = 32'h0;
      rst_n = 1'b0;
      repeat (2) tick();
      check("reset.req",       64'(dmem_req),  64'd0);
      check("reset.stall",     64'(mem_stall), 64'd0);
      check("reset.stall_cnt", 64'(stall_cnt), 64'd0);
      rst_n = 1'b1;
      tick();

      // Word load, zero-wait.
      set_op(32'h100, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      push("wload", 32'h100, 1'b0, 4'hF, 32'h0, 1'b0, 32'hDEADBEEF, 32'h0);
      serve_word(0, 32'hDEADBEEF);
      idle_op();
      check("wload.stall_cnt", 64'(stall_cnt), 64'd0);

      // Double load, two wait cycles per word.
      set_op(32'h200, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0);
      push("dload.w0", 32'h200, 1'b0, 4'hF, 32'h0, 1'b1, 32'h0, 32'h0);
      push("dload.w1", 32'h204, 1'b0, 4'hF, 32'h0, 1'b0, 32'h11111111, 32'h22222222);
      serve_word(2, 32'h11111111);
      serve_word(2, 32'h22222222);
      idle_op();
      check("dload.stall_cnt", 64'(stall_cnt), 64'd5);

      // Byte store at the top lane.
      set_op(32'h303, 1'b0, 1'b1, 1'b1, 1'b0, 32'h55AA00AB, 32'h0);
      push("sbyte", 32'h300, 1'b1, 4'b1000, 32'hABABABAB, 1'b0, 32'h0, 32'h0);
      serve_word(0, 32'h0);
      idle_op();

      // Double store, one wait on word 0.
      set_op(32'h400, 1'b0, 1'b1, 1'b0, 1'b1, 32'hCAFEF00D, 32'h12345678);
      push("dstore.w0", 32'h400, 1'b1, 4'hF, 32'hCAFEF00D, 1'b1, 32'h0, 32'h0);
      push("dstore.w1", 32'h404, 1'b1, 4'hF, 32'h12345678, 1'b0, 32'h0, 32'h0);
      serve_word(1, 32'h0);
      serve_word(0, 32'h0);
      idle_op();
      check("dstore.stall_cnt", 64'(stall_cnt), 64'd7);

      // Misaligned accesses are suppressed.
      set_op(32'h102, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      #1;
      check("mis_word.flag",  64'(misalign_M), 64'd1);
      check("mis_word.req",   64'(dmem_req),   64'd0);
      check("mis_word.stall", 64'(mem_stall),  64'd0);
      set_op(32'h204, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0);
      #1;
      check("mis_dbl.flag",  64'(misalign_M), 64'd1);
      check("mis_dbl.req",   64'(dmem_req),   64'd0);
      check("mis_dbl.stall", 64'(mem_stall),  64'd0);
      tick();
      check("mis.stall_cnt", 64'(stall_cnt), 64'd7);
      idle_op();
      tick();

      // Reset while waiting on word 1 of a double load.
      set_op(32'h200, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0);
      push("rst.w0", 32'h200, 1'b0, 4'hF, 32'h0, 1'b1, 32'h0, 32'h0);
      serve_word(0, 32'h33333333);
      #2;
      check("rst_mid.pre_stall", 64'(mem_stall), 64'd1);
      rst_n = 1'b0;
      #1;
      check("rst_mid.req",   64'(dmem_req),  64'd0);
      check("rst_mid.stall", 64'(mem_stall), 64'd0);
      idle_op();
      tick();
      rst_n = 1'b1;
      tick();
      check("rst_mid.stall_cnt",     64'(stall_cnt), 64'd0);
      check("rst_mid.sat_stall_cnt", 64'(s_cnt),     64'd0);

      // A fresh zero-wait load after reset must start from IDLE (base address, no stall).
      set_op(32'h104, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      push("post_rst", 32'h104, 1'b0, 4'hF, 32'h0, 1'b0, 32'h0BADF00D, 32'h0);
      serve_word(0, 32'h0BADF00D);
      idle_op();

      // Ten stall cycles: the 3-bit counter saturates at 7, the wide one reaches 10.
      set_op(32'h100, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      push("sat", 32'h100, 1'b0, 4'hF, 32'h0, 1'b0, 32'h5A5A5A5A, 32'h0);
      serve_word(10, 32'h5A5A5A5A);
      idle_op();
      check("sat.cnt3",  64'(s_cnt),     64'd7);
      check("sat.cnt32", 64'(stall_cnt), 64'd10);

      repeat (3) tick();
      check("scoreboard.drained", 64'(exp_q.size()), 64'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule : tb_mem_access_unit
